mem_access_ctrl: RTL

//  Initiator side of the unified data/instruction memory port. Accepts fetch/load/store requests

---
 rtl/mem_ctl_pkg.sv | 29 ++
 rtl/memctl_stall_counter.sv | 36 +++
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctl_pkg.sv
// Shared definitions for the memory access controller.
//   mem_op_e    : request op codes carried on req_op
//   state_e     : controller FSM states
//   IO_PREFIX   : top two address bits that select memory-mapped IO
//   STALL_CNT_W : width of the optional stall cycle counter
package mem_ctl_pkg;

  typedef enum logic [1:0] {
    OP_FETCH   = 2'b00,
    OP_LOAD    = 2'b01,
    OP_STORE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

  localparam logic [1:0] IO_PREFIX   = 2'b11;
  localparam int         STALL_CNT_W = 32;

  function automatic logic is_io_region(input logic [1:0] addr_top);
    return (addr_top == IO_PREFIX);
  endfunction

endpackage

// File: rtl/memctl_stall_counter.sv
// Saturating counter of cycles in which a request waits on a busy controller.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears the count
//   en    : count this cycle
//   count : current count, sticks at all-ones
module memctl_stall_counter
  import mem_ctl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic [STALL_CNT_W-1:0] count
);

  logic [STALL_CNT_W-1:0] count_q;
  logic [STALL_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {STALL_CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the unified data/instruction memory port.
// Takes FETCH/LOAD/STORE requests over valid/ready, drives the memory's
// port-1 and fetch signals around its one-cycle registered read, and returns
// read data (or a store acknowledge) over a valid/ready response channel.
// Addresses with the top two bits at 2'b11 are memory-mapped IO.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata       : op code, address or PC, store data
//   resp_valid/resp_ready           : response handshake, held until accepted
//   resp_data/resp_err/resp_io      : read data (0 for STORE/illegal), illegal
//                                     op flag, IO-region flag
//   mem_addr/mem_wdata/mem_we       : memory port 1
//   mem_rdata                       : memory port 1 read data
//   mem_pc/mem_fetch/mem_instr      : memory instruction fetch port
//   stall_cycles (optional)         : saturating count of req_valid&&!req_ready
//
// Build option: define MEMCTL_STALL_CNT_EN to add the stall_cycles output.
module mem_access_ctrl
  import mem_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  resp_io,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_pc,
  output logic                  mem_fetch,
  input  logic [DATA_WIDTH-1:0] mem_instr
`ifdef MEMCTL_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  state_e                state_q,     state_d;
  mem_op_e               op_q,        op_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_pc_q,    mem_pc_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q,  resp_err_d;
  logic                  resp_io_q,   resp_io_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_pc_d    = mem_pc_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    resp_io_d   = resp_io_q;

    unique case (state_q)
      ST_IDLE: begin
        // req_ready is high here, so req_valid alone completes the handshake.
        if (req_valid) begin
          op_d        = mem_op_e'(req_op);
          resp_io_d   = is_io_region(req_addr[ADDR_WIDTH-1 -: 2]);
          resp_err_d  = 1'b0;
          resp_data_d = '0;
          unique case (mem_op_e'(req_op))
            OP_FETCH: begin
              mem_pc_d = req_addr;
              state_d  = ST_ISSUE;
            end
            OP_LOAD: begin
              mem_addr_d = req_addr;
              state_d    = ST_ISSUE;
            end
            OP_STORE: begin
              mem_addr_d  = req_addr;
              mem_wdata_d = req_wdata;
              state_d     = ST_ISSUE;
            end
            default: begin
              // Illegal op: answer immediately, memory is never touched.
              resp_err_d = 1'b1;
              state_d    = ST_RESP;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        // A store needs no read-back, so it skips the capture cycle.
        state_d = (op_q == OP_STORE) ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Address/PC stay put: the memory's IO read mux decodes the live address.
        resp_data_d = (op_q == OP_FETCH) ? mem_instr : mem_rdata;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FETCH;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_pc_q    <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      resp_io_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_pc_q    <= mem_pc_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      resp_io_q   <= resp_io_d;
    end
  end

  // All outputs decode registered state only.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign resp_io    = resp_io_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_pc     = mem_pc_q;
  assign mem_we     = (state_q == ST_ISSUE) && (op_q == OP_STORE);
  assign mem_fetch  = (state_q == ST_ISSUE) && (op_q == OP_FETCH);

`ifdef MEMCTL_STALL_CNT_EN
  logic stall_en;
  assign stall_en = req_valid && !req_ready;

  memctl_stall_counter u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .count (stall_cycles)
  );
`endif

endmodule
